// File: rtl/serial_bit_reducer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_bit_reducer_pkg
//  Description : Shared types for the serial bit reducer: reduction op
//                encoding and the frame state machine states.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package serial_bit_reducer_pkg;

   // Reduction ops, encoded exactly as presented on up_op / down_op.
   typedef enum logic [1:0] {
      OP_OR   = 2'b00,
      OP_AND  = 2'b01,
      OP_XOR  = 2'b10,
      OP_XNOR = 2'b11
   } red_op_e;

   // Frame tracking: IDLE waits for a frame's first beat, ACCUM folds the rest.
   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_e;

endpackage : serial_bit_reducer_pkg
`default_nettype wire

// File: rtl/reduce_op_cell.sv
`default_nettype none
// ============================================================================
//  Module      : reduce_op_cell
//  Description : Combinational 2-input logic op built only from 2:1 mux
//                selections, in the style of the gate-from-mux exercises.
//  Ports       : a, b - operands
//                op   - 00 OR, 01 AND, 10 XOR, 11 XNOR
//                y    - result
//  Revision    : 1.0  initial release
// ============================================================================
module reduce_op_cell
   import serial_bit_reducer_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic [1:0] op,
   output logic       y
);

   logic w_or;
   logic w_and;
   logic w_xor;
   logic w_xnor;
   logic w_lo;
   logic w_hi;

   // Each gate is a mux with a as the select line.
   assign w_or   = a ? 1'b1 : b;
   assign w_and  = a ? b    : 1'b0;
   assign w_xor  = a ? ~b   : b;
   assign w_xnor = a ? b    : ~b;

   // Two-level mux tree on the op bits picks the gate.
   assign w_lo = op[0] ? w_and  : w_or;
   assign w_hi = op[0] ? w_xnor : w_xor;
   assign y    = op[1] ? w_hi   : w_lo;

endmodule : reduce_op_cell
`default_nettype wire

// File: rtl/serial_bit_reducer.sv
`default_nettype none
// ============================================================================
//  Module      : serial_bit_reducer
//  Description : Reduces framed serial 1-bit beats with OR/AND/XOR/XNOR and
//                presents the reduced bit and beat count on a registered
//                valid/ready output.
//  Ports       : clk, rst_n                  - clock, async active-low reset
//                up_valid/up_ready           - input beat handshake
//                up_data, up_last, up_op     - beat bit, frame end, op
//                down_valid/down_ready       - result handshake
//                down_data, down_count,
//                down_sat, down_op           - frame result
//  Revision    : 1.0  initial release
// ============================================================================
module serial_bit_reducer
   import serial_bit_reducer_pkg::*;
#(
   parameter int CNT_W = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic             up_data,
   input  logic             up_last,
   input  logic [1:0]       up_op,
   output logic             down_valid,
   input  logic             down_ready,
   output logic             down_data,
   output logic [CNT_W-1:0] down_count,
   output logic             down_sat,
   output logic [1:0]       down_op
);

   localparam logic [CNT_W-1:0] c_cnt_max = '1;
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

   state_e           r_state;
   logic             r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_sat;
   red_op_e          r_op;

   logic             w_accept;
   logic [1:0]       w_cell_op;
   logic             w_acc_upd;
   logic             w_cnt_at_max;
   logic             w_f_acc;
   logic [CNT_W-1:0] w_f_cnt;
   logic             w_f_sat;
   red_op_e          w_f_op;
   logic             w_res_data;

   // A slot frees up either when nothing is held or the held result retires.
   assign up_ready = !down_valid || down_ready;
   assign w_accept = up_valid && up_ready;

   // XNOR frames accumulate as XOR; the inversion is applied once at frame end.
   assign w_cell_op = (r_op == OP_XNOR) ? OP_XOR : r_op;

   reduce_op_cell u_reduce_op_cell (
      .a  (r_acc),
      .b  (up_data),
      .op (w_cell_op),
      .y  (w_acc_upd)
   );

   assign w_cnt_at_max = (r_cnt == c_cnt_max);

   // Frame state after folding in the current beat.
   always_comb begin
      w_f_acc = up_data;
      w_f_cnt = c_cnt_one;
      w_f_sat = 1'b0;
      w_f_op  = red_op_e'(up_op);
      if (r_state == ACCUM) begin
         w_f_acc = w_acc_upd;
         w_f_cnt = w_cnt_at_max ? r_cnt : r_cnt + c_cnt_one;
         w_f_sat = r_sat | w_cnt_at_max;
         w_f_op  = r_op;
      end
   end

   assign w_res_data = w_f_acc ^ (w_f_op == OP_XNOR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_acc      <= 1'b0;
         r_cnt      <= '0;
         r_sat      <= 1'b0;
         r_op       <= OP_OR;
         down_valid <= 1'b0;
         down_data  <= 1'b0;
         down_count <= '0;
         down_sat   <= 1'b0;
         down_op    <= 2'b00;
      end else begin
         if (w_accept) begin
            r_acc   <= w_f_acc;
            r_cnt   <= w_f_cnt;
            r_sat   <= w_f_sat;
            r_op    <= w_f_op;
            r_state <= up_last ? IDLE : ACCUM;
         end

         // Completing beat loads the result; an accepted beat implies the
         // output slot is free, so held results are never overwritten.
         if (w_accept && up_last) begin
            down_valid <= 1'b1;
            down_data  <= w_res_data;
            down_count <= w_f_cnt;
            down_sat   <= w_f_sat;
            down_op    <= w_f_op;
         end else if (down_ready) begin
            down_valid <= 1'b0;
         end
      end
   end

endmodule : serial_bit_reducer
`default_nettype wire

// File: tb/tb_serial_bit_reducer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_bit_reducer
//  Description : Self-checking bench for serial_bit_reducer (CNT_W = 3) using
//                a frame-level reference model and a result scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_bit_reducer;

   localparam int CW   = 3;
   localparam int CMAX = 7;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          up_valid = 1'b0;
   logic          up_ready;
   logic          up_data = 1'b0;
   logic          up_last = 1'b0;
   logic [1:0]    up_op = 2'b00;
   logic          down_valid;
   logic          down_ready = 1'b0;
   logic          down_data;
   logic [CW-1:0] down_count;
   logic          down_sat;
   logic [1:0]    down_op;

   serial_bit_reducer #(.CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .up_valid   (up_valid),
      .up_ready   (up_ready),
      .up_data    (up_data),
      .up_last    (up_last),
      .up_op      (up_op),
      .down_valid (down_valid),
      .down_ready (down_ready),
      .down_data  (down_data),
      .down_count (down_count),
      .down_sat   (down_sat),
      .down_op    (down_op)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic       d;
      int         cnt;
      logic       sat;
      logic [1:0] op;
   } res_t;

   res_t       q[$];
   int         cur_len  = 0;
   int         cur_ones = 0;
   logic [1:0] cur_op   = 2'b00;
   logic       exp_dv   = 1'b0;

   function automatic res_t model(input int len, input int ones, input logic [1:0] op);
      res_t r;
      case (op)
         2'b00:   r.d = (ones > 0);
         2'b01:   r.d = (ones == len);
         2'b10:   r.d = ((ones % 2) == 1);
         default: r.d = ((ones % 2) == 0);
      endcase
      r.cnt = (len > CMAX) ? CMAX : len;
      r.sat = (len > CMAX);
      r.op  = op;
      return r;
   endfunction

   always @(negedge clk) begin
      logic nxt;
      if (!rst_n) begin
         q.delete();
         cur_len  = 0;
         cur_ones = 0;
         exp_dv   = 1'b0;
      end else begin
         chk("down_valid", 32'(down_valid), 32'(exp_dv));
         chk("up_ready", 32'(up_ready), 32'(!down_valid || down_ready));
         if (down_valid) begin
            if (q.size() == 0) begin
               chk("spurious_result", 32'd1, 32'd0);
            end else begin
               chk("down_data",  32'(down_data),  32'(q[0].d));
               chk("down_count", 32'(down_count), 32'(q[0].cnt));
               chk("down_sat",   32'(down_sat),   32'(q[0].sat));
               chk("down_op",    32'(down_op),    32'(q[0].op));
               if (down_ready) void'(q.pop_front());
            end
         end
         nxt = down_valid && !down_ready;
         if (up_valid && up_ready) begin
            if (cur_len == 0) cur_op = up_op;
            cur_len++;
            cur_ones += int'(up_data);
            if (up_last) begin
               q.push_back(model(cur_len, cur_ones, cur_op));
               cur_len  = 0;
               cur_ones = 0;
               nxt      = 1'b1;
            end
         end
         exp_dv = nxt;
      end
   end

   // ---------------- downstream ready driver ----------------
   int rdy_mode = 0;   // 0 always ready, 1 random, 2 stalled

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       down_ready = 1'b1;
            1:       down_ready = 1'($urandom_range(0, 1));
            default: down_ready = 1'b0;
         endcase
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic sync_pos();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         up_data = 1'($urandom_range(0, 1));
         up_last = 1'($urandom_range(0, 1));
         up_op   = 2'($urandom_range(0, 3));
         sync_pos();
      end
   endtask

   task automatic send_beat(input logic d, input logic l, input logic [1:0] op);
      int n = 0;
      bit done = 0;
      up_valid = 1'b1;
      up_data  = d;
      up_last  = l;
      up_op    = op;
      while (!done) begin
         @(negedge clk);
         if (up_ready) done = 1;
         else if (++n > 200) begin
            chk("beat_timeout", 32'd0, 32'd1);
            done = 1;
         end
         sync_pos();
      end
      up_valid = 1'b0;
      up_data  = 1'($urandom_range(0, 1));
      up_last  = 1'($urandom_range(0, 1));
      up_op    = 2'($urandom_range(0, 3));
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_left", 32'(q.size()), 32'd0);
      sync_pos();
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic exp_ops [4];
      exp_ops = '{1'b1, 1'b0, 1'b0, 1'b1};

      idle(3);
      rst_n = 1'b1;
      idle(2);

      // Reset in the middle of a frame.
      send_beat(1'b1, 1'b0, 2'b00);
      send_beat(1'b0, 1'b0, 2'b00);
      send_beat(1'b1, 1'b0, 2'b00);
      rst_n = 1'b0;
      #1;
      chk("rst_down_valid", 32'(down_valid), 32'd0);
      chk("rst_up_ready",   32'(up_ready),   32'd1);
      idle(2);
      rst_n = 1'b1;
      idle(1);
      send_beat(1'b1, 1'b1, 2'b00);
      @(negedge clk);
      chk("rst_next_valid", 32'(down_valid), 32'd1);
      chk("rst_next_data",  32'(down_data),  32'd1);
      chk("rst_next_count", 32'(down_count), 32'd1);
      sync_pos();

      // Every op over bits 0,1,1.
      for (int op = 0; op < 4; op++) begin
         send_beat(1'b0, 1'b0, 2'(op));
         send_beat(1'b1, 1'b0, 2'(op));
         send_beat(1'b1, 1'b1, 2'(op));
         @(negedge clk);
         chk("ops_data",  32'(down_data),  32'(exp_ops[op]));
         chk("ops_count", 32'(down_count), 32'd3);
         chk("ops_op",    32'(down_op),    32'(op));
         sync_pos();
      end

      // Op is latched on the first beat only.
      send_beat(1'b0, 1'b0, 2'b00);
      send_beat(1'b0, 1'b0, 2'b01);
      send_beat(1'b1, 1'b1, 2'b01);
      @(negedge clk);
      chk("latch_data", 32'(down_data), 32'd1);
      chk("latch_op",   32'(down_op),   32'd0);
      sync_pos();

      // Backpressure with a pending last beat, then release without a bubble.
      rdy_mode = 2;
      idle(1);
      send_beat(1'b1, 1'b1, 2'b10);
      up_valid = 1'b1;
      up_data  = 1'b0;
      up_last  = 1'b1;
      up_op    = 2'b00;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_up_ready", 32'(up_ready),   32'd0);
         chk("bp_valid",    32'(down_valid), 32'd1);
         chk("bp_data",     32'(down_data),  32'd1);
         sync_pos();
      end
      rdy_mode   = 0;
      down_ready = 1'b1;
      send_beat(1'b0, 1'b1, 2'b00);
      @(negedge clk);
      chk("bp_new_valid", 32'(down_valid), 32'd1);
      chk("bp_new_data",  32'(down_data),  32'd0);
      chk("bp_new_op",    32'(down_op),    32'd0);
      sync_pos();

      // Back-to-back one-beat frames.
      send_beat(1'b1, 1'b1, 2'b01);
      send_beat(1'b0, 1'b1, 2'b01);
      send_beat(1'b1, 1'b1, 2'b01);
      drain();

      // Saturation: 9 beats at CNT_W=3, then a short frame.
      for (int i = 0; i < 9; i++) send_beat(1'b1, 1'(i == 8), 2'b01);
      @(negedge clk);
      chk("sat_count", 32'(down_count), 32'd7);
      chk("sat_flag",  32'(down_sat),   32'd1);
      chk("sat_data",  32'(down_data),  32'd1);
      sync_pos();
      send_beat(1'b1, 1'b0, 2'b01);
      send_beat(1'b1, 1'b1, 2'b01);
      @(negedge clk);
      chk("post_sat_count", 32'(down_count), 32'd2);
      chk("post_sat_flag",  32'(down_sat),   32'd0);
      sync_pos();

      // Randomized frames with gaps and random downstream ready.
      rdy_mode = 1;
      for (int f = 0; f < 300; f++) begin
         int len;
         len = $urandom_range(1, 10);
         for (int b = 0; b < len; b++) begin
            idle($urandom_range(0, 2));
            send_beat(1'($urandom_range(0, 1)), 1'(b == len - 1), 2'($urandom_range(0, 3)));
         end
      end
      rdy_mode = 0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_serial_bit_reducer
`default_nettype wire
